// File: rtl/dsc_seq_pkg.sv
// Shared types and helpers for the dsc_mul_sequencer block.
package dsc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   // Plain vector encodings of the FSM states, used by the state register.
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   function automatic int res_width(input int data_width, input int num_inputs);
      return data_width * num_inputs;
   endfunction

endpackage

// File: rtl/dsc_seq_fifo.sv
// Operand-set buffer: synchronous FIFO with registered occupancy count.
module dsc_seq_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; stale entries are never read while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/dsc_mul_sequencer.sv
// Operand sequencer in front of dsc_serial_mul: buffers operand sets, runs
// one multiplication at a time and returns products on a valid/ready stream.
// Optional watchdog abort enabled by defining DSC_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | mul_en low; pop next operand set when the buffer has one
// RUN   | mul_en high, mul_data held; wait for mul_done (or watchdog)
// DRAIN | mul_en low; hold result until the consumer takes it
module dsc_mul_sequencer
   import dsc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 2**(DATA_WIDTH*NUM_INPUTS) + 8,
   localparam int RES_WIDTH = res_width(DATA_WIDTH, NUM_INPUTS)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [DATA_WIDTH-1:0][NUM_INPUTS-1:0] in_data,
   output logic                                  mul_en,
   output logic [DATA_WIDTH-1:0][NUM_INPUTS-1:0] mul_data,
   input  logic [RES_WIDTH-1:0]                  mul_result,
   input  logic                                  mul_done,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [RES_WIDTH-1:0]                  out_data,
   output logic                                  out_err,
   output logic                                  busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]           state;
   logic [RES_WIDTH-1:0] fifo_rd_data;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 timeout_hit;
   logic                 mul_en_q;
   logic [RES_WIDTH-1:0] mul_data_q;
   logic                 out_valid_q;
   logic [RES_WIDTH-1:0] out_data_q;

   // Ready comes from the registered count, so a full buffer cannot take a
   // push in the same cycle it is popped.
   assign in_ready = (fifo_count < CW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready && !fifo_full;
   assign pop      = (state == ST_IDLE) && !fifo_empty;

   dsc_seq_fifo #(
      .WIDTH (RES_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef DSC_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wdog_cnt;
   logic          err_q;

   // Watchdog down-counter: loaded at launch, terminal count on the
   // TIMEOUT-th RUN cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_cnt <= '0;
      end else if (pop) begin
         wdog_cnt <= TW'(TIMEOUT - 1);
      end else if (state == ST_RUN && wdog_cnt != '0) begin
         wdog_cnt <= wdog_cnt - 1'b1;
      end
   end

   assign timeout_hit = (state == ST_RUN) && (wdog_cnt == '0);

   // Error flag for an aborted operation; a real done on the limit cycle wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state == ST_RUN) begin
         if (mul_done)         err_q <= 1'b0;
         else if (timeout_hit) err_q <= 1'b1;
      end else if (state == ST_DRAIN && out_ready) begin
         err_q <= 1'b0;
      end
   end

   assign out_err = err_q;
`else
   // The watchdog limit has no effect in this build.
   localparam int timeout_unused = TIMEOUT;

   assign timeout_hit = 1'b0;
   assign out_err     = 1'b0;
`endif

   // Launch / collect FSM with the operand and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         mul_en_q    <= 1'b0;
         mul_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  mul_data_q <= fifo_rd_data;
                  mul_en_q   <= 1'b1;
                  state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (mul_done) begin
                  out_data_q  <= mul_result;
                  out_valid_q <= 1'b1;
                  mul_en_q    <= 1'b0;
                  state       <= ST_DRAIN;
               end else if (timeout_hit) begin
                  out_data_q  <= '0;
                  out_valid_q <= 1'b1;
                  mul_en_q    <= 1'b0;
                  state       <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               mul_en_q    <= 1'b0;
               out_valid_q <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign mul_en    = mul_en_q;
   assign mul_data  = mul_data_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dsc_mul_sequencer.sv
// Self-checking bench for dsc_mul_sequencer with a behavioural multiplier.
module tb_dsc_mul_sequencer;

   localparam int DW    = 5;
   localparam int NI    = 2;
   localparam int RW    = DW * NI;
   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [RW-1:0] in_data = '0;
   logic          mul_en;
   logic [RW-1:0] mul_data;
   logic [RW-1:0] mul_result = '0;
   logic          mul_done;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [RW-1:0] out_data;
   logic          out_err;
   logic          busy;

   logic mdl_done  = 1'b0;
   logic spur_done = 1'b0;
   bit   mdl_on    = 1'b1;
   int   lat       = 4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [RW-1:0] data;
      bit            err;
   } exp_t;

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            lat;
      logic [RW-1:0] exp;
   } vec_t;

   exp_t          exp_q[$];
   logic [RW-1:0] launch_q[$];

   assign mul_done = mdl_done | spur_done;

   always #5 clk = ~clk;

   dsc_mul_sequencer #(
      .DATA_WIDTH (DW),
      .NUM_INPUTS (NI),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .mul_en     (mul_en),
      .mul_data   (mul_data),
      .mul_result (mul_result),
      .mul_done   (mul_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_err    (out_err),
      .busy       (busy)
   );

   function automatic logic [RW-1:0] prod(input logic [RW-1:0] d);
      logic [RW-1:0] a;
      logic [RW-1:0] b;
      a = {{(RW-DW){1'b0}}, d[RW-1:DW]};
      b = {{(RW-DW){1'b0}}, d[DW-1:0]};
      return a * b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic note_accept(input logic [RW-1:0] d, input bit to);
      exp_t e;
      e.data = to ? '0 : prod(d);
      e.err  = to;
      launch_q.push_back(d);
      exp_q.push_back(e);
   endtask

   task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit to);
      int budget;
      bit rdy;
      budget   = 3000;
      in_valid = 1'b1;
      in_data  = {a, b};
      do begin
         rdy = in_ready;
         tick();
         budget--;
      end while (!rdy && budget > 0);
      in_valid = 1'b0;
      if (!rdy) chk("push_timeout", 32'(rdy), 1);
      else      note_accept({a, b}, to);
   endtask

   task automatic wait_out(input string name, input int budget);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         tick();
         n++;
      end
      if (!out_valid) chk(name, 32'(out_valid), 1);
   endtask

   task automatic wait_empty(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         tick();
         n++;
      end
      chk(name, 32'(exp_q.size()), 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  1);
      chk({tag, "_mul_en"},    32'(mul_en),    0);
      chk({tag, "_mul_data"},  32'(mul_data),  0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_data"},  32'(out_data),  0);
      chk({tag, "_out_err"},   32'(out_err),   0);
      chk({tag, "_busy"},      32'(busy),      0);
   endtask

   task automatic mid_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values(tag);
      exp_q.delete();
      launch_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   // Behavioural multiplier: done pulse after lat cycles of en, product of operands.
   initial begin : mult_model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (mdl_done) begin
            mdl_done = 1'b0;
         end else if (mul_en && mdl_on) begin
            cnt++;
            if (cnt >= lat) begin
               mul_result = prod(mul_data);
               mdl_done   = 1'b1;
            end
         end
         if (!mul_en) cnt = 0;
      end
   end

   // Stream monitor: launch order, en low gap, operand stability, result order.
   initial begin : monitor
      bit            prev_en;
      int            low_cnt;
      logic [RW-1:0] held;
      bit            stable;
      exp_t          e;
      prev_en = 1'b0;
      low_cnt = 100;
      held    = '0;
      stable  = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            if (mul_en && !prev_en) begin
               chk("en_low_gap_ok", 32'(low_cnt >= 2), 1);
               if (launch_q.size() == 0) fail("unexpected_launch");
               else chk("launch_data", 32'(mul_data), 32'(launch_q.pop_front()));
               held   = mul_data;
               stable = 1'b1;
            end
            if (mul_en && prev_en && mul_data !== held) stable = 1'b0;
            if (!mul_en && prev_en) chk("mul_data_stable", 32'(stable), 1);
            low_cnt = mul_en ? 0 : low_cnt + 1;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  fail("extra_result");
               end else begin
                  e = exp_q.pop_front();
                  chk("result_data", 32'(out_data), 32'(e.data));
                  chk("result_err",  32'(out_err),  32'(e.err));
               end
            end
            prev_en = mul_en;
         end else begin
            prev_en = 1'b0;
            low_cnt = 100;
         end
      end
   end

   initial begin : global_guard
      #3000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin : main
      vec_t          vecs[7];
      int            n;
      int            bad;
      int            seen;
      logic [RW-1:0] held;
      bit            acc;
      int            accepted;

      vecs[0] = '{a: 5'd3,  b: 5'd7,  lat: 3, exp: 10'd21};
      vecs[1] = '{a: 5'd0,  b: 5'd31, lat: 1, exp: 10'd0};
      vecs[2] = '{a: 5'd31, b: 5'd31, lat: 7, exp: 10'd961};
      vecs[3] = '{a: 5'd31, b: 5'd1,  lat: 2, exp: 10'd31};
      vecs[4] = '{a: 5'd16, b: 5'd2,  lat: 5, exp: 10'd32};
      vecs[5] = '{a: 5'd1,  b: 5'd1,  lat: 1, exp: 10'd1};
      vecs[6] = '{a: 5'd12, b: 5'd10, lat: 9, exp: 10'd120};

      // Reset state.
      repeat (3) tick();
      check_reset_values("reset");
      rst = 1'b1;
      tick();
      check_reset_values("post_reset");

      // Single op {3,7} with a 1024-cycle multiplier.
      lat = 1024;
      out_ready = 1'b0;
      push(5'd3, 5'd7, 1'b0);
      chk("single_en_after_accept", 32'(mul_en), 0);
      chk("single_busy", 32'(busy), 1);
      tick();
      chk("single_en_launch", 32'(mul_en), 1);
      chk("single_mul_data", 32'(mul_data), 32'({5'd3, 5'd7}));
      n = 1;
      for (int i = 0; i < 1200 && !out_valid; i++) begin
         tick();
         if (mul_en) n++;
      end
      chk("single_out_valid", 32'(out_valid), 1);
      chk("single_en_cycles", 32'(n), 1024);
      chk("single_out_data", 32'(out_data), 21);
      chk("single_out_err", 32'(out_err), 0);
      chk("single_en_low_after_done", 32'(mul_en), 0);
      out_ready = 1'b1;
      tick();
      chk("single_valid_cleared", 32'(out_valid), 0);
      out_ready = 1'b0;

      // Table of directed operand sets.
      foreach (vecs[i]) begin
         lat = vecs[i].lat;
         push(vecs[i].a, vecs[i].b, 1'b0);
         wait_out("vec_wait", 200);
         chk("vec_out_data", 32'(out_data), 32'(vecs[i].exp));
         chk("vec_out_err", 32'(out_err), 0);
         out_ready = 1'b1;
         tick();
         chk("vec_valid_cleared", 32'(out_valid), 0);
         out_ready = 1'b0;
      end

      // Back-to-back: one set running plus four buffered fills the FIFO.
      lat = 6;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(DW'(i + 2), DW'(3 * i + 1), 1'b0);
      chk("b2b_in_ready_full", 32'(in_ready), 32'((5 - 1) < DEPTH));
      chk("b2b_busy", 32'(busy), 1);
      push(5'd29, 5'd30, 1'b0);
      wait_empty("b2b_drain", 500);
      out_ready = 1'b0;

      // Backpressure: result held for 50 cycles with another set waiting.
      lat = 4;
      push(5'd9, 5'd9, 1'b0);
      push(5'd2, 5'd3, 1'b0);
      wait_out("bp_wait", 100);
      held = out_data;
      chk("bp_out_data", 32'(held), 81);
      bad  = 0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (out_data !== held || !out_valid) bad++;
         if (mul_en) seen++;
      end
      chk("bp_result_held", 32'(bad), 0);
      chk("bp_no_launch", 32'(seen), 0);
      out_ready = 1'b1;
      wait_empty("bp_drain", 200);
      out_ready = 1'b0;

      // Spurious done in IDLE and in DRAIN.
      tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      chk("spur_idle_valid", 32'(out_valid), 0);
      chk("spur_idle_busy", 32'(busy), 0);
      chk("spur_idle_en", 32'(mul_en), 0);
      push(5'd4, 5'd5, 1'b0);
      wait_out("spur_wait", 100);
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      chk("spur_drain_valid", 32'(out_valid), 1);
      chk("spur_drain_data", 32'(out_data), 20);
      chk("spur_drain_en", 32'(mul_en), 0);
      out_ready = 1'b1;
      tick();
      chk("spur_valid_cleared", 32'(out_valid), 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid || mul_en) seen++;
      end
      chk("spur_no_extra", 32'(seen), 0);

      // Reset in RUN with three sets queued.
      lat = 300;
      for (int i = 0; i < 4; i++) push(DW'(i + 5), DW'(i + 9), 1'b0);
      repeat (5) tick();
      chk("rst_mid_in_run", 32'(mul_en), 1);
      mid_reset("rst_mid");
      lat = 3;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (out_valid || mul_en || busy) seen++;
      end
      chk("rst_queue_discarded", 32'(seen), 0);
      out_ready = 1'b0;

      // Watchdog behaviour with the multiplier silent.
      mdl_on = 1'b0;
`ifdef DSC_SEQ_TIMEOUT_EN
      push(5'd6, 5'd6, 1'b1);
      tick();
      n = mul_en ? 1 : 0;
      for (int i = 0; i < 100 && !out_valid; i++) begin
         tick();
         if (mul_en) n++;
      end
      chk("to_out_valid", 32'(out_valid), 1);
      chk("to_run_cycles", 32'(n), TO);
      chk("to_out_err", 32'(out_err), 1);
      chk("to_out_data", 32'(out_data), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`else
      push(5'd6, 5'd6, 1'b0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (mul_en && !out_valid) n++;
      end
      chk("no_to_stays_run", 32'(n), 100);
      mid_reset("no_to_reset");
`endif
      mdl_on = 1'b1;

      // Randomized traffic against the scoreboard.
      accepted = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         acc = in_valid && in_ready;
         tick();
         if (acc) begin
            note_accept(in_data, 1'b0);
            accepted++;
         end
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = RW'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (!mul_en) lat = $urandom_range(1, 12);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_empty("rand_drain", 3000);
      chk("rand_launch_q_empty", 32'(launch_q.size()), 0);
      chk("rand_traffic_seen", 32'(accepted > 20), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
